// File: rtl/vgachargen_pkg.sv
// Shared constants for the VGA text-mode timing front end: default 640x480@60
// timing, the glyph cell geometry derived from it and the sync polarity codes.
package vgachargen_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int CHAR_W_DEF   = 8;
  localparam int CHAR_H_DEF   = 16;
  localparam int PIPE_LAT_DEF = 2;

  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int COLS_DEF     = H_ACTIVE_DEF / CHAR_W_DEF;
  localparam int ROWS_DEF     = V_ACTIVE_DEF / CHAR_H_DEF;

  // Asserted level of a sync pulse.
  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

  // Cell sizes must be powers of two so that column and glyph offsets are bit slices.
  function automatic bit is_pow2(input int x);
    return (x > 0) && ((x & (x - 1)) == 0);
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Enable-gated delay line for the video flags. Each bit resets to its own
// value so sync lines come out of reset at their deasserted level.
module vga_sync_delay #(
  parameter int               DEPTH   = 2,
  parameter int               WIDTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst, en};
    assign dout = din;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage [DEPTH];

    // Shift one position per pixel strobe; hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      end else if (en) begin
        stage[0] <= din;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_text_timing.sv
// VGA text-mode timing generator: raster counters, character buffer address
// and glyph coordinates (registered, no strobe delay), plus active/sync flags
// delayed by PIPE_LAT strobes to line up with the character RAM + glyph ROM.
module vga_text_timing
  import vgachargen_pkg::*;
#(
  parameter int   H_ACTIVE  = H_ACTIVE_DEF,
  parameter int   H_FP      = H_FP_DEF,
  parameter int   H_SYNC    = H_SYNC_DEF,
  parameter int   H_BP      = H_BP_DEF,
  parameter int   V_ACTIVE  = V_ACTIVE_DEF,
  parameter int   V_FP      = V_FP_DEF,
  parameter int   V_SYNC    = V_SYNC_DEF,
  parameter int   V_BP      = V_BP_DEF,
  parameter logic HSYNC_POL = SYNC_ACTIVE_LOW,
  parameter logic VSYNC_POL = SYNC_ACTIVE_LOW,
  parameter int   CHAR_W    = CHAR_W_DEF,
  parameter int   CHAR_H    = CHAR_H_DEF,
  parameter int   PIPE_LAT  = PIPE_LAT_DEF,
  localparam int  COLS      = H_ACTIVE / CHAR_W,
  localparam int  ROWS      = V_ACTIVE / CHAR_H,
  localparam int  ADDR_W    = $clog2(COLS * ROWS),
  localparam int  CX_W      = $clog2(CHAR_W),
  localparam int  CY_W      = $clog2(CHAR_H)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pix_en_i,
  output logic [ADDR_W-1:0] cell_addr_o,
  output logic [CX_W-1:0]   glyph_x_o,
  output logic [CY_W-1:0]   glyph_y_o,
  output logic              active_o,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic              frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0]     H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]     H_VIS      = HW'(H_ACTIVE);
  localparam logic [HW-1:0]     H_SYNC_ON  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]     H_SYNC_OFF = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0]     V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]     V_VIS      = VW'(V_ACTIVE);
  localparam logic [VW-1:0]     V_SYNC_ON  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]     V_SYNC_OFF = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [ADDR_W-1:0] COLS_STEP  = ADDR_W'(COLS);

  if (!is_pow2(CHAR_W) || CHAR_W < 2 || (H_ACTIVE % CHAR_W) != 0) begin : g_bad_char_w
    $error("vga_text_timing: CHAR_W must be a power of two (>= 2) dividing H_ACTIVE");
  end
  if (!is_pow2(CHAR_H) || CHAR_H < 2 || (V_ACTIVE % CHAR_H) != 0) begin : g_bad_char_h
    $error("vga_text_timing: CHAR_H must be a power of two (>= 2) dividing V_ACTIVE");
  end
  if (PIPE_LAT < 0 || PIPE_LAT > 7) begin : g_bad_pipe_lat
    $error("vga_text_timing: PIPE_LAT must be in 0..7");
  end

  logic [HW-1:0]     h_cnt;
  logic [VW-1:0]     v_cnt;
  logic [VW-1:0]     v_next;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] col;
  logic              h_last, v_last, visible, row_cross, h_in_sync, v_in_sync;
  logic              act_r, hs_r, vs_r;
  logic [2:0]        flags_q;

  assign h_last    = (h_cnt == H_LAST);
  assign v_last    = (v_cnt == V_LAST);
  assign v_next    = v_last ? '0 : v_cnt + VW'(1);
  // The next line starts a new character row inside the visible area.
  assign row_cross = (v_next[CY_W-1:0] == '0) && (v_next < V_VIS);
  assign visible   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign h_in_sync = (h_cnt >= H_SYNC_ON) && (h_cnt < H_SYNC_OFF);
  assign v_in_sync = (v_cnt >= V_SYNC_ON) && (v_cnt < V_SYNC_OFF);
  assign col       = ADDR_W'(h_cnt >> CX_W);

  // Raster counters and row base; row base stays on the last row through blanking.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      row_base <= '0;
    end else if (pix_en_i) begin
      h_cnt <= h_last ? '0 : h_cnt + HW'(1);
      if (h_last) begin
        v_cnt <= v_next;
        if (v_last)         row_base <= '0;
        else if (row_cross) row_base <= row_base + COLS_STEP;
      end
    end
  end

  // Register address, glyph offsets and raw video flags for the current counter state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cell_addr_o <= '0;
      glyph_x_o   <= '0;
      glyph_y_o   <= '0;
      act_r       <= 1'b0;
      hs_r        <= ~HSYNC_POL;
      vs_r        <= ~VSYNC_POL;
    end else if (pix_en_i) begin
      act_r <= visible;
      hs_r  <= h_in_sync ? HSYNC_POL : ~HSYNC_POL;
      vs_r  <= v_in_sync ? VSYNC_POL : ~VSYNC_POL;
      if (visible) begin
        cell_addr_o <= row_base + col;
        glyph_x_o   <= h_cnt[CX_W-1:0];
        glyph_y_o   <= v_cnt[CY_W-1:0];
      end else begin
        cell_addr_o <= '0;
        glyph_x_o   <= '0;
        glyph_y_o   <= '0;
      end
    end
  end

  // One-clock pulse when pixel (0,0) is strobed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) frame_start_o <= 1'b0;
    else       frame_start_o <= pix_en_i && (h_cnt == '0) && (v_cnt == '0);
  end

  vga_sync_delay #(
    .DEPTH   (PIPE_LAT),
    .WIDTH   (3),
    .RST_VAL ({1'b0, ~HSYNC_POL, ~VSYNC_POL})
  ) u_sync_delay (
    .clk  (clk_i),
    .rst  (rst_i),
    .en   (pix_en_i),
    .din  ({act_r, hs_r, vs_r}),
    .dout (flags_q)
  );

  assign {active_o, hsync_o, vsync_o} = flags_q;

endmodule

// File: doc/vga_text_timing.md
VGA_TEXT_TIMING -- requirements
Module: vga_text_timing

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, meaning visible pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, meaning horizontal porches and sync width in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, meaning visible lines.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, meaning vertical porches and sync width in lines.
REQ-005 SHALL have parameters HSYNC_POL/VSYNC_POL, default 0/0, meaning asserted sync level (0 = active-low).
REQ-006 SHALL have parameters CHAR_W/CHAR_H, default 8/16, meaning glyph cell size in pixels; each SHALL be a power of two dividing H_ACTIVE/V_ACTIVE.
REQ-007 SHALL have parameter PIPE_LAT, default 2, range 0..7, meaning pixel-enable delay applied to sync/active outputs to match character RAM plus glyph ROM latency.
REQ-008 clk_i  input  1  pixel-domain clock; one clock; all logic on its rising edge.
REQ-009 rst_i  input  1  reset, asynchronous and active-high.
REQ-010 pix_en_i  input  1  pixel strobe; counters and delay line advance only when high.
REQ-011 cell_addr_o  output  clog2(COLS*ROWS)  character buffer address, COLS = H_ACTIVE/CHAR_W, ROWS = V_ACTIVE/CHAR_H.
REQ-012 glyph_x_o  output  clog2(CHAR_W)  pixel column inside cell; glyph_y_o  output  clog2(CHAR_H)  pixel row inside cell.
REQ-013 active_o  output  1  visible-region flag, delayed PIPE_LAT strobes.
REQ-014 hsync_o / vsync_o  output  1 each  sync pulses at configured polarity, delayed PIPE_LAT strobes.
REQ-015 frame_start_o  output  1  single-clock pulse at first pixel of frame, undelayed.

Function
REQ-016 h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of horizontal parameters) on each pix_en_i, wrapping to 0.
REQ-017 v_cnt SHALL increment on h_cnt wrap and wrap to 0 after V_TOTAL-1.
REQ-018 With pix_en_i low all counters, address outputs and the delay line SHALL hold.
REQ-019 Undelayed active SHALL equal (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE).
REQ-020 Undelayed hsync SHALL be asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vsync analogously on v_cnt, changing at h_cnt wrap.
REQ-021 glyph_x_o SHALL equal h_cnt mod CHAR_W and glyph_y_o v_cnt mod CHAR_H during active; both SHALL be 0 outside active.
REQ-022 cell_addr_o SHALL equal row*COLS + col during active, produced by incremental row-base accumulation (add COLS on each row crossing), no multiplier; 0 outside active.
REQ-023 Row base SHALL clear to 0 at v_cnt wrap; last visible cell SHALL be COLS*ROWS-1.
REQ-024 cell_addr_o and glyph_x_o/glyph_y_o SHALL be registered, valid the clock after the counter state they describe, with zero pix_en delay.
REQ-025 active_o, hsync_o, vsync_o SHALL be a PIPE_LAT-deep shift register advancing only on pix_en_i; PIPE_LAT=0 SHALL pass the registered values directly.
REQ-026 frame_start_o SHALL pulse for exactly one clk_i when pix_en_i is high and h_cnt=0, v_cnt=0.

Reset
REQ-027 Asserting rst_i at any time, including mid-line, SHALL immediately clear h_cnt, v_cnt, row base, cell_addr_o, glyph_x_o, glyph_y_o, active_o, frame_start_o and the delay line.
REQ-028 During reset hsync_o/vsync_o SHALL sit at deasserted level (~HSYNC_POL/~VSYNC_POL), delay-line stages likewise.
REQ-029 First pix_en_i after reset release SHALL be treated as pixel (0,0) and SHALL raise frame_start_o.

Structure
REQ-030 Package vgachargen_pkg SHALL hold the default timing constants, derived COLS/ROWS/H_TOTAL/V_TOTAL and the sync polarity constants.
REQ-031 One sub-module vga_sync_delay SHALL implement the enable-gated PIPE_LAT delay line with per-bit reset value.
REQ-032 Elaboration SHALL fail on CHAR_W/CHAR_H not dividing the active sizes or PIPE_LAT > 7.

Verification
REQ-033 pix_en_i=1 constantly, defaults: hsync_o low for 96 clocks starting 658 clocks after line start (656+PIPE_LAT), period 800.
REQ-034 Full frame: vsync_o low for 2 lines beginning at line 490, frame_start_o period exactly 420000 clocks.
REQ-035 At h=8, v=16: cell_addr_o=81, glyph_x_o=0, glyph_y_o=0; at h=639, v=479: cell_addr_o=2399, glyph_x_o=7, glyph_y_o=15; at h=640: cell_addr_o=0.
REQ-036 pix_en_i toggled 1-of-5: outputs identical to reference model stretched 5x; 10-clock low gap holds all outputs.
REQ-037 rst_i pulsed at h=300, v=200: next clock all outputs at reset values; first strobe after release gives frame_start_o=1.
REQ-038 Override HSYNC_POL=1, PIPE_LAT=0, CHAR_W=16: hsync_o high h=656..751 undelayed, cell_addr_o increments every 16 pixels, 40 columns.
